// File: rtl/mesi_line_ctrl_pkg.sv
// Shared MESI types and the snoop next-state/response function used by the
// line controller and its snoop-response sub-module.
package mesi_pkg;

    typedef enum logic [1:0] {
        I = 2'b00,
        S = 2'b01,
        E = 2'b10,
        M = 2'b11
    } mesi_state_e;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        BUS_RD   = 2'd1,
        BUS_RDX  = 2'd2,
        BUS_UPGR = 2'd3
    } bus_cmd_e;

    typedef enum logic {
        PR_RD = 1'b0,
        PR_WR = 1'b1
    } pr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS_WAIT,
        ST_DONE
    } fsm_e;

    typedef struct packed {
        mesi_state_e nxt;
        logic        hit;
        logic        hitm;
        logic        err;
    } snoop_resp_t;

    function automatic snoop_resp_t snoop_next(input mesi_state_e st, input bus_cmd_e cmd);
        snoop_resp_t r;
        r.nxt  = st;
        r.hit  = 1'b0;
        r.hitm = 1'b0;
        r.err  = 1'b0;
        case (cmd)
            BUS_RD: begin
                case (st)
                    M:       begin r.nxt = S; r.hitm = 1'b1; end
                    E, S:    begin r.nxt = S; r.hit  = 1'b1; end
                    default: ;
                endcase
            end
            BUS_RDX: begin
                case (st)
                    M:       begin r.nxt = I; r.hitm = 1'b1; end
                    E, S:    begin r.nxt = I; r.hit  = 1'b1; end
                    default: ;
                endcase
            end
            BUS_UPGR: begin
                // An upgrade can only come from a sharer, so an owned copy here is a protocol fault.
                case (st)
                    S:       begin r.nxt = I; r.hit = 1'b1; end
                    M, E:    r.err = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mesi_snoop_resp.sv
// Combinational snoop response: (line state, snooped command) -> next state,
// hit/hitm and protocol-error indication.
module mesi_snoop_resp
    import mesi_pkg::*;
(
    input  mesi_state_e state,
    input  bus_cmd_e    cmd,
    output mesi_state_e next_state,
    output logic        hit,
    output logic        hitm,
    output logic        err
);

    snoop_resp_t resp;

    always_comb begin
        resp       = snoop_next(state, cmd);
        next_state = resp.nxt;
        hit        = resp.hit;
        hitm       = resp.hitm;
        err        = resp.err;
    end

endmodule

// File: rtl/mesi_line_ctrl.sv
// MESI line-state controller: one processor request at a time through the
// shared bus, plus a registered snoop response every cycle.
module mesi_line_ctrl
    import mesi_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    parameter int SET_W    = $clog2(NUM_SETS),
    parameter int WAY_W    = ($clog2(NUM_WAYS) > 0 ? $clog2(NUM_WAYS) : 1)
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pr_valid,
    output logic             pr_ready,
    input  logic             pr_op,
    input  logic [SET_W-1:0] pr_set,
    input  logic [WAY_W-1:0] pr_way,
    output logic             pr_done,
    output logic [1:0]       pr_state,
    output logic             bus_req,
    output logic [1:0]       bus_cmd,
    input  logic             bus_gnt,
    input  logic             bus_shared,
    input  logic             sn_valid,
    input  logic [1:0]       sn_cmd,
    input  logic [SET_W-1:0] sn_set,
    input  logic [WAY_W-1:0] sn_way,
    output logic             sn_hit,
    output logic             sn_hitm,
    output logic             proto_err
);

    localparam int IDX_W  = SET_W + WAY_W;
    localparam int NLINES = 1 << IDX_W;

    mesi_state_e lines [NLINES];

    fsm_e             state_q, state_d;
    bus_cmd_e         req_cmd_q, req_cmd_d;
    logic [IDX_W-1:0] req_idx_q;

    logic [IDX_W-1:0] sn_idx, pr_idx, wr_idx;
    mesi_state_e      sn_cur, sn_nxt, pr_cur, wr_val;
    logic             sn_hit_c, sn_hitm_c, sn_err_c, sn_act, wr_en;

    assign sn_idx = {sn_set, sn_way};
    assign pr_idx = {pr_set, pr_way};
    assign sn_cur = lines[sn_idx];
    // A granted bus cycle owns the line array; a snoop in that cycle is dropped.
    assign sn_act = sn_valid && !bus_gnt;

    mesi_snoop_resp u_snoop (
        .state      (sn_cur),
        .cmd        (bus_cmd_e'(sn_cmd)),
        .next_state (sn_nxt),
        .hit        (sn_hit_c),
        .hitm       (sn_hitm_c),
        .err        (sn_err_c)
    );

    // Processor decision sees the line as the concurrent snoop leaves it.
    always_comb begin
        pr_cur = lines[pr_idx];
        if (sn_act && (sn_idx == pr_idx)) begin
            pr_cur = sn_nxt;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_cmd_d = req_cmd_q;
        wr_en     = 1'b0;
        wr_val    = I;
        wr_idx    = pr_idx;
        case (state_q)
            ST_IDLE: begin
                if (pr_valid) begin
                    if (pr_op == PR_WR) begin
                        case (pr_cur)
                            M:       state_d = ST_DONE;
                            E:       begin wr_en = 1'b1; wr_val = M; state_d = ST_DONE; end
                            S:       begin req_cmd_d = BUS_UPGR; state_d = ST_BUS_WAIT; end
                            default: begin req_cmd_d = BUS_RDX;  state_d = ST_BUS_WAIT; end
                        endcase
                    end else if (pr_cur == I) begin
                        req_cmd_d = BUS_RD;
                        state_d   = ST_BUS_WAIT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BUS_WAIT: begin
                if (bus_gnt) begin
                    wr_en   = 1'b1;
                    wr_idx  = req_idx_q;
                    wr_val  = (req_cmd_q == BUS_RD) ? (bus_shared ? S : E) : M;
                    state_d = ST_DONE;
                end else if (sn_act && (sn_idx == req_idx_q) && (req_cmd_q == BUS_UPGR)
                             && (sn_nxt == I)) begin
                    req_cmd_d = BUS_RDX;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_cmd_q <= NONE;
            req_idx_q <= '0;
            sn_hit    <= 1'b0;
            sn_hitm   <= 1'b0;
            proto_err <= 1'b0;
            for (int unsigned i = 0; i < NLINES; i++) begin
                lines[IDX_W'(i)] <= I;
            end
        end else begin
            state_q   <= state_d;
            req_cmd_q <= req_cmd_d;
            if (state_q == ST_IDLE && pr_valid) begin
                req_idx_q <= pr_idx;
            end
            sn_hit  <= sn_act && sn_hit_c;
            sn_hitm <= sn_act && sn_hitm_c;
            if (sn_act) begin
                lines[sn_idx] <= sn_nxt;
            end
            if (wr_en) begin
                lines[wr_idx] <= wr_val;
            end
            if ((bus_gnt && sn_valid) || (bus_gnt && state_q != ST_BUS_WAIT)
                || (sn_act && sn_err_c)) begin
                proto_err <= 1'b1;
            end
        end
    end

    assign pr_ready = (state_q == ST_IDLE);
    assign pr_done  = (state_q == ST_DONE);
    assign pr_state = pr_done ? lines[req_idx_q] : I;
    assign bus_req  = (state_q == ST_BUS_WAIT);
    assign bus_cmd  = bus_req ? req_cmd_q : NONE;

endmodule

// File: tb/tb_mesi_line_ctrl.sv
// Scoreboard bench for mesi_line_ctrl: expected completion states are queued
// at request issue and checked when pr_done appears.
module tb_mesi_line_ctrl;

    localparam logic [1:0] L_I = 2'b00, L_S = 2'b01, L_E = 2'b10, L_M = 2'b11;
    localparam logic [1:0] C_NONE = 2'd0, C_RD = 2'd1, C_RDX = 2'd2, C_UPGR = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n, pr_valid, pr_op, bus_gnt, bus_shared, sn_valid;
    logic [3:0] pr_set, sn_set;
    logic [1:0] pr_way, sn_way, sn_cmd;
    logic       pr_ready, pr_done, bus_req, sn_hit, sn_hitm, proto_err;
    logic [1:0] pr_state, bus_cmd;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    mesi_line_ctrl #(.NUM_SETS(16), .NUM_WAYS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pr_valid(pr_valid), .pr_ready(pr_ready), .pr_op(pr_op),
        .pr_set(pr_set), .pr_way(pr_way),
        .pr_done(pr_done), .pr_state(pr_state),
        .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_gnt(bus_gnt), .bus_shared(bus_shared),
        .sn_valid(sn_valid), .sn_cmd(sn_cmd), .sn_set(sn_set), .sn_way(sn_way),
        .sn_hit(sn_hit), .sn_hitm(sn_hitm), .proto_err(proto_err)
    );

    // Every helper starts and ends just after a falling edge.
    task automatic issue(input logic op, input logic [3:0] s, input logic [1:0] w,
                         input logic [1:0] exp_state);
        pr_valid = 1'b1; pr_op = op; pr_set = s; pr_way = w;
        exp_q.push_back(exp_state);
        @(negedge clk);
        pr_valid = 1'b0;
    endtask

    task automatic grant(input logic shared);
        bus_gnt = 1'b1; bus_shared = shared;
        @(negedge clk);
        bus_gnt = 1'b0; bus_shared = 1'b0;
    endtask

    task automatic snoop(input logic [1:0] cmd, input logic [3:0] s, input logic [1:0] w);
        sn_valid = 1'b1; sn_cmd = cmd; sn_set = s; sn_way = w;
        @(negedge clk);
        sn_valid = 1'b0; sn_cmd = C_NONE;
    endtask

    task automatic wait_done(output int cyc, output logic [1:0] st, output logic [1:0] ex);
        cyc = 0;
        while (!pr_done && cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
        st = pr_state;
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
    endtask

    task automatic to_idle();
        for (int k = 0; k < 6 && !pr_ready; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs = {pr_ready, pr_done, pr_state, bus_req, bus_cmd, sn_hit, sn_hitm, proto_err};
        n_tests++;
        if (obs !== 10'b1_0_00_0_00_0_0_0) begin
            n_fail++; $display("FAIL reset_outputs got=%b want=%b", obs, 10'b1000000000);
        end
    endtask

    task automatic test_read_miss_hit();
        int cyc; logic [1:0] st, ex; logic seen_req;
        issue(1'b0, 4'd3, 2'd1, L_E);
        n_tests++;
        if ({bus_req, bus_cmd, pr_ready} !== {1'b1, C_RD, 1'b0}) begin
            n_fail++; $display("FAIL rd_miss_req got req=%b cmd=%0d rdy=%b want 1/1/0", bus_req, bus_cmd, pr_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if ({bus_req, bus_cmd, pr_done} !== {1'b1, C_RD, 1'b0}) begin
                n_fail++; $display("FAIL rd_miss_hold got req=%b cmd=%0d done=%b want 1/1/0", bus_req, bus_cmd, pr_done);
            end
        end
        grant(1'b0);
        wait_done(cyc, st, ex);
        n_tests++;
        if (cyc != 0 || st !== ex) begin
            n_fail++; $display("FAIL rd_miss_done got lat=%0d st=%0d want lat=0 st=%0d", cyc, st, ex);
        end
        to_idle();
        issue(1'b0, 4'd3, 2'd1, L_E);
        seen_req = bus_req;
        wait_done(cyc, st, ex);
        n_tests++;
        if (cyc != 0 || st !== ex || seen_req !== 1'b0) begin
            n_fail++; $display("FAIL rd_hit got lat=%0d st=%0d req=%b want lat=0 st=%0d req=0", cyc, st, seen_req, ex);
        end
        to_idle();
    endtask

    task automatic test_write_exclusive();
        int cyc; logic [1:0] st, ex; logic seen_req;
        issue(1'b1, 4'd3, 2'd1, L_M);
        seen_req = bus_req;
        wait_done(cyc, st, ex);
        n_tests++;
        if (cyc != 0 || st !== ex || seen_req !== 1'b0) begin
            n_fail++; $display("FAIL wr_e_silent got lat=%0d st=%0d req=%b want lat=0 st=%0d req=0", cyc, st, seen_req, ex);
        end
        to_idle();
        snoop(C_RD, 4'd3, 2'd1);
        n_tests++;
        if ({sn_hitm, sn_hit} !== 2'b10) begin
            n_fail++; $display("FAIL snoop_rd_on_m got hitm=%b hit=%b want 1/0", sn_hitm, sn_hit);
        end
        // The line should now be S: a write must upgrade.
        issue(1'b1, 4'd3, 2'd1, L_M);
        n_tests++;
        if ({bus_req, bus_cmd} !== {1'b1, C_UPGR}) begin
            n_fail++; $display("FAIL wr_s_upgr got req=%b cmd=%0d want 1/3", bus_req, bus_cmd);
        end
        grant(1'b0);
        wait_done(cyc, st, ex);
        n_tests++;
        if (cyc != 0 || st !== ex) begin
            n_fail++; $display("FAIL wr_s_done got lat=%0d st=%0d want lat=0 st=%0d", cyc, st, ex);
        end
        to_idle();
    endtask

    task automatic test_upgrade_race();
        int cyc; logic [1:0] st, ex;
        issue(1'b0, 4'd5, 2'd2, L_S);
        grant(1'b1);
        wait_done(cyc, st, ex);
        n_tests++;
        if (cyc != 0 || st !== ex) begin
            n_fail++; $display("FAIL rd_shared_done got lat=%0d st=%0d want lat=0 st=%0d", cyc, st, ex);
        end
        to_idle();
        issue(1'b1, 4'd5, 2'd2, L_M);
        n_tests++;
        if ({bus_req, bus_cmd} !== {1'b1, C_UPGR}) begin
            n_fail++; $display("FAIL race_upgr got req=%b cmd=%0d want 1/3", bus_req, bus_cmd);
        end
        snoop(C_RDX, 4'd5, 2'd2);
        n_tests++;
        if ({sn_hit, sn_hitm, bus_req, bus_cmd} !== {1'b1, 1'b0, 1'b1, C_RDX}) begin
            n_fail++; $display("FAIL race_to_rdx got hit=%b hitm=%b req=%b cmd=%0d want 1/0/1/2", sn_hit, sn_hitm, bus_req, bus_cmd);
        end
        grant(1'b0);
        wait_done(cyc, st, ex);
        n_tests++;
        if (cyc != 0 || st !== ex) begin
            n_fail++; $display("FAIL race_done got lat=%0d st=%0d want lat=0 st=%0d", cyc, st, ex);
        end
        to_idle();
    endtask

    task automatic test_same_cycle();
        int cyc; logic [1:0] st, ex;
        issue(1'b0, 4'd9, 2'd3, L_S);
        grant(1'b1);
        wait_done(cyc, st, ex);
        to_idle();
        sn_valid = 1'b1; sn_cmd = C_RDX; sn_set = 4'd9; sn_way = 2'd3;
        issue(1'b0, 4'd9, 2'd3, L_S);
        sn_valid = 1'b0; sn_cmd = C_NONE;
        n_tests++;
        if ({sn_hit, pr_done, bus_req, bus_cmd} !== {1'b1, 1'b0, 1'b1, C_RD}) begin
            n_fail++; $display("FAIL same_cycle_snoop_first got hit=%b done=%b req=%b cmd=%0d want 1/0/1/1", sn_hit, pr_done, bus_req, bus_cmd);
        end
        grant(1'b1);
        wait_done(cyc, st, ex);
        n_tests++;
        if (cyc != 0 || st !== ex) begin
            n_fail++; $display("FAIL same_cycle_done got lat=%0d st=%0d want lat=0 st=%0d", cyc, st, ex);
        end
        to_idle();
    endtask

    task automatic test_snoop_m();
        int cyc; logic [1:0] st, ex;
        n_tests++;
        if (proto_err !== 1'b0) begin
            n_fail++; $display("FAIL no_err_yet got proto_err=%b want 0", proto_err);
        end
        snoop(C_RDX, 4'd5, 2'd2);
        n_tests++;
        if ({sn_hitm, sn_hit} !== 2'b10) begin
            n_fail++; $display("FAIL snoop_rdx_on_m got hitm=%b hit=%b want 1/0", sn_hitm, sn_hit);
        end
        snoop(C_RD, 4'd5, 2'd2);
        n_tests++;
        if ({sn_hitm, sn_hit} !== 2'b00) begin
            n_fail++; $display("FAIL snoop_after_inval got hitm=%b hit=%b want 0/0", sn_hitm, sn_hit);
        end
        issue(1'b0, 4'd7, 2'd0, L_E);
        grant(1'b0);
        wait_done(cyc, st, ex);
        to_idle();
        snoop(C_UPGR, 4'd7, 2'd0);
        n_tests++;
        if ({proto_err, sn_hit, sn_hitm} !== 3'b100) begin
            n_fail++; $display("FAIL upgr_on_e got err=%b hit=%b hitm=%b want 1/0/0", proto_err, sn_hit, sn_hitm);
        end
        issue(1'b0, 4'd7, 2'd0, L_E);
        wait_done(cyc, st, ex);
        n_tests++;
        if (cyc != 0 || st !== ex) begin
            n_fail++; $display("FAIL upgr_on_e_unchanged got lat=%0d st=%0d want lat=0 st=%0d", cyc, st, ex);
        end
        to_idle();
        repeat (3) @(negedge clk);
        n_tests++;
        if (proto_err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky got proto_err=%b want 1", proto_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] sets [3] = '{4'd3, 4'd7, 4'd9};
        logic [1:0] ways [3] = '{2'd1, 2'd0, 2'd3};
        issue(1'b0, 4'd2, 2'd0, L_S);
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        n_tests++;
        if ({bus_req, pr_ready, proto_err, bus_cmd} !== {1'b0, 1'b1, 1'b0, C_NONE}) begin
            n_fail++; $display("FAIL reset_mid got req=%b rdy=%b err=%b cmd=%0d want 0/1/0/0", bus_req, pr_ready, proto_err, bus_cmd);
        end
        rst_n = 1'b1;
        grant(1'b1);
        n_tests++;
        if ({proto_err, pr_done, pr_ready} !== 3'b101) begin
            n_fail++; $display("FAIL stray_gnt got err=%b done=%b rdy=%b want 1/0/1", proto_err, pr_done, pr_ready);
        end
        for (int k = 0; k < 3; k++) begin
            snoop(C_RD, sets[k], ways[k]);
            n_tests++;
            if ({sn_hit, sn_hitm} !== 2'b00) begin
                n_fail++; $display("FAIL reset_line_%0d got hit=%b hitm=%b want 0/0", k, sn_hit, sn_hitm);
            end
        end
        issue(1'b0, 4'd3, 2'd1, L_E);
        n_tests++;
        if ({bus_req, bus_cmd} !== {1'b1, C_RD}) begin
            n_fail++; $display("FAIL reset_line_miss got req=%b cmd=%0d want 1/1", bus_req, bus_cmd);
        end
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; pr_valid = 1'b0; pr_op = 1'b0; pr_set = '0; pr_way = '0;
        bus_gnt = 1'b0; bus_shared = 1'b0;
        sn_valid = 1'b0; sn_cmd = C_NONE; sn_set = '0; sn_way = '0;
        @(negedge clk);
        test_reset();
        test_read_miss_hit();
        test_write_exclusive();
        test_upgrade_race();
        test_same_cycle();
        test_snoop_m();
        test_reset_mid();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1);
    end

endmodule
